// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter:
// FSM encoding, status-word bit positions and register offsets.
package mmio_uart_tx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_CNT   = 4;
    localparam int STAT_CNT_W = 5;

    localparam logic [31:0] OFF_DATA   = 32'd0;
    localparam logic [31:0] OFF_STATUS = 32'd4;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Small synchronous FIFO holding bytes waiting to be serialised.
// A push into a full FIFO is accepted only when a pop frees a slot.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA register feeds a FIFO,
// STATUS register is polled combinationally, tx is registered.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        busy
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          data_wr;
    logic          stat_wr;
    logic          pop;
    logic          full;
    logic          empty;
    logic [7:0]    dout;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tx_q;
    logic          overflow;
    logic [31:0]   status;
    logic          unused_wdata;

    assign data_wr = MemWrite && (DataAdr == BASE_ADDR + OFF_DATA);
    assign stat_wr = MemWrite && (DataAdr == BASE_ADDR + OFF_STATUS);
    assign pop     = (state == ST_IDLE) && !empty;
    assign busy    = !empty || (state != ST_IDLE);
    assign tx      = tx_q;

    assign unused_wdata = ^WriteData[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .reset (reset),
        .push  (data_wr),
        .pop   (pop),
        .din   (WriteData[7:0]),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Sticky overflow: a DATA write that finds no free slot sets it.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (data_wr && full && !pop) begin
            overflow <= 1'b1;
        end else if (stat_wr && WriteData[STAT_OVF]) begin
            overflow <= 1'b0;
        end
    end

    // Frame serialiser; tx changes only on state/bit boundaries.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state   <= ST_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (!empty) begin
                        shift <= dout;
                        baud  <= '0;
                        state <= ST_START;
                        tx_q  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud == BAUD_LAST) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                        tx_q    <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud == BAUD_LAST) begin
                        baud  <= '0;
                        shift <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx_q  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_q    <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud == BAUD_LAST) begin
                        baud  <= '0;
                        state <= ST_IDLE;
                        tx_q  <= 1'b1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Status word assembly for polling.
    always_comb begin
        status                          = '0;
        status[STAT_FULL]               = full;
        status[STAT_EMPTY]              = empty;
        status[STAT_BUSY]               = busy;
        status[STAT_OVF]                = overflow;
        status[STAT_CNT +: STAT_CNT_W]  = STAT_CNT_W'(count);
    end

    assign ReadData = (DataAdr == BASE_ADDR + OFF_STATUS) ? status : '0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: reset, single frame, back-to-back,
// overflow, full push+pop, and reset mid-frame.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] STAT = 32'hFFFF_0004;
    localparam logic [31:0] OTHR = 32'hFFFF_0008;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        tx;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int w0 = 0;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (8)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    // Edge counter: after edge k (plus settle) cyc == k.
    always @(posedge CLK) cyc <= cyc + 1;

    // Line monitor: decodes frames at mid-bit on the falling clock.
    logic       mon_act = 1'b0;
    int         mon_pos = 0;
    int         mon_st = 0;
    logic [7:0] mon_b = '0;
    logic [7:0] q_byte [$];
    logic       q_stop [$];
    int         q_start [$];

    always @(negedge CLK) begin
        if (reset !== 1'b1) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                mon_act = 1'b1;
                mon_pos = 0;
                mon_st = cyc;
            end
        end else begin
            mon_pos++;
            if (mon_pos >= 6 && mon_pos <= 34 && ((mon_pos - 6) % 4) == 0)
                mon_b[3'((mon_pos - 6) / 4)] = tx;
            if (mon_pos == 38) begin
                q_byte.push_back(mon_b);
                q_stop.push_back(tx);
                q_start.push_back(mon_st);
                mon_act = 1'b0;
            end
        end
    end

    task automatic clear_q();
        q_byte.delete();
        q_stop.delete();
        q_start.delete();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        DataAdr = a;
        WriteData = d;
        MemWrite = 1'b1;
        @(posedge CLK);
        #1;
        MemWrite = 1'b0;
        DataAdr = '0;
        WriteData = '0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: got %b want 1", tx);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        DataAdr = STAT;
        #1;
        checks++;
        if (ReadData !== 32'h0000_0002) begin
            errors++;
            $display("FAIL reset_status: got %h want 00000002", ReadData);
        end
        DataAdr = BASE;
        #1;
        checks++;
        if (ReadData !== 32'h0) begin
            errors++;
            $display("FAIL read_nonstatus: got %h want 0", ReadData);
        end
        DataAdr = '0;
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        logic       e;
        bit         ok;
        b = 8'h55;
        clear_q();
        wr(BASE, 32'h0000_0155);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_pre: tx=%b busy=%b want 1 1", tx, busy);
        end
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            #1;
            if (k < 4) e = 1'b0;
            else if (k < 36) e = b[3'((k - 4) / 4)];
            else e = 1'b1;
            checks++;
            if (tx !== e) begin
                errors++;
                $display("FAIL frame_bit cycle %0d: got %b want %b", k, tx, e);
            end
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_busy_stop: got %b want 1", busy);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_busy_end: got %b want 0", busy);
        end
        wait_idle(10, ok);
        checks++;
        if (q_byte.size() != 1 || q_byte[0] !== 8'h55) begin
            errors++;
            $display("FAIL frame_decode: got n=%0d b=%h want n=1 b=55",
                     q_byte.size(), q_byte.size() ? q_byte[0] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        bit         ok;
        exp[0] = 8'h41;
        exp[1] = 8'h42;
        exp[2] = 8'h43;
        clear_q();
        wr(BASE, 32'h41);
        w0 = cyc;
        wr(BASE, 32'h42);
        wr(BASE, 32'h43);
        DataAdr = STAT;
        #1;
        checks++;
        if (ReadData[8:4] !== 5'd2) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 2", ReadData[8:4]);
        end
        DataAdr = '0;
        wait_idle(300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_timeout: busy=%b want 0", busy);
        end
        checks++;
        if (q_byte.size() != 3) begin
            errors++;
            $display("FAIL b2b_nframes: got %0d want 3", q_byte.size());
        end else begin
            checks++;
            if (q_start[0] != w0 + 1) begin
                errors++;
                $display("FAIL b2b_latency: got %0d want %0d", q_start[0], w0 + 1);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_byte[i] !== exp[i] || q_stop[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_byte%0d: got %h/%b want %h/1",
                             i, q_byte[i], q_stop[i], exp[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (q_start[i] - q_start[i-1] != 41) begin
                    errors++;
                    $display("FAIL b2b_gap%0d: got %0d want 41",
                             i, q_start[i] - q_start[i-1]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        clear_q();
        wr(BASE, 32'hA0);
        w0 = cyc;
        for (int i = 1; i <= 9; i++) wr(BASE, 32'hA0 + i);
        DataAdr = STAT;
        #1;
        checks++;
        if (ReadData !== 32'h0000_008D) begin
            errors++;
            $display("FAIL ovf_full: got %h want 0000008d", ReadData);
        end
        wr(STAT, 32'h7);
        DataAdr = STAT;
        #1;
        checks++;
        if (ReadData !== 32'h0000_008D) begin
            errors++;
            $display("FAIL ovf_noclear: got %h want 0000008d", ReadData);
        end
        wr(OTHR, 32'h5A);
        DataAdr = STAT;
        #1;
        checks++;
        if (ReadData !== 32'h0000_008D) begin
            errors++;
            $display("FAIL other_addr: got %h want 0000008d", ReadData);
        end
        wr(STAT, 32'h8);
        DataAdr = STAT;
        #1;
        checks++;
        if (ReadData !== 32'h0000_0085) begin
            errors++;
            $display("FAIL ovf_clear: got %h want 00000085", ReadData);
        end
        DataAdr = '0;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] e;
        bit         ok;
        wait_until(w0 + 41);
        DataAdr = STAT;
        #1;
        checks++;
        if (ReadData !== 32'h0000_0085) begin
            errors++;
            $display("FAIL pp_pre: got %h want 00000085", ReadData);
        end
        wr(BASE, 32'hB5);
        DataAdr = STAT;
        #1;
        checks++;
        if (ReadData !== 32'h0000_0085) begin
            errors++;
            $display("FAIL pp_post: got %h want 00000085", ReadData);
        end
        DataAdr = '0;
        wait_idle(600, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL pp_timeout: busy=%b want 0", busy);
        end
        repeat (50) @(posedge CLK);
        #1;
        checks++;
        if (q_byte.size() != 10) begin
            errors++;
            $display("FAIL pp_nframes: got %0d want 10", q_byte.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                e = (i == 9) ? 8'hB5 : 8'(8'hA0 + i);
                checks++;
                if (q_byte[i] !== e) begin
                    errors++;
                    $display("FAIL pp_byte%0d: got %h want %h", i, q_byte[i], e);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        bit tx_bad;
        clear_q();
        wr(BASE, 32'h00);
        w0 = cyc;
        wr(BASE, 32'h11);
        wait_until(w0 + 17);
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: tx=%b busy=%b want 0 1", tx, busy);
        end
        reset = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: tx=%b busy=%b want 1 0", tx, busy);
        end
        DataAdr = STAT;
        #1;
        checks++;
        if (ReadData !== 32'h0000_0002) begin
            errors++;
            $display("FAIL mid_status: got %h want 00000002", ReadData);
        end
        DataAdr = '0;
        reset = 1'b1;
        tx_bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge CLK);
            #1;
            if (tx !== 1'b1) tx_bad = 1'b1;
        end
        checks++;
        if (tx_bad || q_byte.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_quiet: txlow=%b n=%0d busy=%b want 0 0 0",
                     tx_bad, q_byte.size(), busy);
        end
        wr(BASE, 32'h3C);
        wait_idle(100, ok);
        checks++;
        if (!ok || q_byte.size() != 1) begin
            errors++;
            $display("FAIL mid_after: ok=%b n=%0d want 1 1", ok, q_byte.size());
        end else begin
            checks++;
            if (q_byte[0] !== 8'h3C || q_stop[0] !== 1'b1) begin
                errors++;
                $display("FAIL mid_byte: got %h/%b want 3c/1", q_byte[0], q_stop[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t exceeded", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the processor data bus, downstream of TopProcessor. Consumes MemWrite/DataAdr/WriteData.
Processor stores of characters are buffered in a small FIFO and serialised 8N1, LSB first, on a TX pin. A status register is returned combinationally on ReadData for polling.

Parameters:
BASE_ADDR, 32'hFFFF_0000, word address of the DATA register; STATUS is at BASE_ADDR+4.
CLKS_PER_BIT, 16, CLK cycles per serial bit; legal range 2..65535.
FIFO_DEPTH, 8, FIFO entries; power of two, 2..16.

Ports:
CLK  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
MemWrite  input  1  processor store strobe
DataAdr  input  32  processor data address
WriteData  input  32  processor store data
ReadData  output  32  status word, combinational; 0 when DataAdr != BASE_ADDR+4
tx  output  1  serial line, idle high
busy  output  1  high while the FIFO is non-empty or a frame is in flight

Behaviour:
- Reset (reset==0 at a CLK edge): FIFO emptied, overflow=0, FSM=IDLE, baud and bit counters=0. tx=1, busy=0, ReadData=status of an empty, idle block.
- Reset mid-frame aborts the frame; tx returns to 1 on the reset edge.
- DATA write: MemWrite==1 && DataAdr==BASE_ADDR. If the FIFO is not full, push WriteData[7:0]; WriteData[31:8] are ignored.
- DATA write while full: the byte is dropped and the sticky overflow bit is set.
- STATUS write: MemWrite==1 && DataAdr==BASE_ADDR+4 && WriteData[3]==1 clears overflow. Other bits are ignored.
- Simultaneous overflow set and clear is impossible, because they use different addresses.
- Writes to other addresses are ignored.
- Status word fields:
  - [0] full
  - [1] empty
  - [2] busy
  - [3] overflow
  - [8:4] count (0..FIFO_DEPTH)
  - other bits 0
- FIFO: circular buffer with read/write pointers and a count.
  - Push and pop in the same cycle are both allowed, including when full (the pop frees a slot). Count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, clear the baud counter, go to START. Otherwise stay, tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
- Latency: a byte written at edge N into an empty idle block is popped at edge N+1. tx falls after edge N+1.
- A frame lasts 10*CLKS_PER_BIT cycles.
- Back-to-back frames have one extra IDLE cycle between frames (tx=1) for each STOP->IDLE->START transition.
- tx is driven from a register (glitch-free).
- busy = !empty || state!=IDLE.
- Baud counter width is $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - the STATUS bit-position constants;
  - the DATA/STATUS address offsets (0, 4).
- One natural sub-module: sync_fifo.
  - Parameters: width 8, depth FIFO_DEPTH.
  - Signals: push, pop, din, dout, full, empty, count.
  - Instantiated once. The top holds address decode, status register and the TX FSM.

Test Plan:
1. Reset low for 2 cycles, then high -> tx=1, busy=0, a read at BASE+4 returns 32'h0000_0002.
2. CLKS_PER_BIT=4. Write 32'h0000_0155 to BASE -> tx is as follows after the write edge:
   - low for 4 cycles;
   - bits 1,0,1,0,1,0,1,0 (4 cycles each);
   - high for 4 cycles;
   - then busy=0.
   Bits 31:8 have no effect.
3. Write bytes 8'h41, 8'h42, 8'h43 on consecutive cycles -> three frames in order 41, 42, 43. Each frame is 40 cycles, separated by exactly one idle-high cycle. Status count reads 2 right after the first pop.
4. DEPTH=8, CLKS_PER_BIT=4. With the FSM holding a frame in flight, write 9 bytes -> status shows full=1, count=8, overflow=1, and the 9th byte is never transmitted.
   - Then write 32'h8 to BASE+4 -> overflow=0.
5. When full, push and pop land on the same edge -> count stays 8, no overflow, and the pushed byte is transmitted last.
6. Assert reset during DATA bit 3 -> tx=1 on the next edge, FIFO empty, no partial frame resumes; a following write transmits normally.
